ga_convergence_monitor: RTL and testbench
=========================================

// Module: ga_convergence_monitor
// PURPOSE
//  Sits downstream of the morphologic GA top level and consumes its cycle, bestIndividual and bestError outputs.
//  Counts fitness evaluations and tracks the best solution seen since arm.
//  Declares the run finished on target error reached, stall limit hit, evaluation limit hit, or external abort.
//  Freezes the winning individual for readout by the host/UART stage.
// PARAMETERS
//  IndividualWidth   64    width of bestIndividual / solution
//  ErrorWidth        5     width of bestError / solutionError
//  EvalCounterWidth  16    width of evalCount
//  StallCounterWidth 8     width of stallCount
//  MaxEvaluations    1000  evaluation limit; 0 disables this check
//  StallLimit        64    evaluations without improvement before stop; 0 disables this check
//  TargetError       0     stop when the tracked error is <= this value
// PORTS
//  clk            in   1                  single clock; all logic on its rising edge
//  rst            in   1                  synchronous, active-high reset
//  arm            in   1                  start (or restart) monitoring
//  abort          in   1                  force stop while running
//  cycle          in   1                  GA fitnessStart indication; only its rising edge is used
//  bestIndividual in   IndividualWidth    GA current best individual
//  bestError      in   ErrorWidth         GA current best error
//  running        out  1                  high in state RUN
//  done           out  1                  high in state DONE
//  doneStrobe     out  1                  one-cycle pulse on entry to DONE
//  reason         out  3                  0 none, 1 target, 2 stall, 3 limit, 4 abort
//  solution       out  IndividualWidth    tracked best individual
//  solutionError  out  ErrorWidth         tracked best error
//  evalCount      out  EvalCounterWidth   rising edges of cycle counted since arm
//  stallCount     out  StallCounterWidth  evaluations since the last improvement
// BEHAVIOUR
//  Reset:
//   - state IDLE; every output 0; internal cyclePrev 0.
//  Edge detection:
//   - rise = cycle & ~cyclePrev.
//   - cyclePrev is registered every cycle in every state.
//  IDLE:
//   - arm=1 -> RUN on the next edge.
//   - On that edge: evalCount=0, stallCount=0, reason=0, solution=0, solutionError=all ones.
//   - abort and rise are ignored.
//  RUN, on rise:
//   - evalCount += 1, saturating at all ones.
//   - If bestError < solutionError (strict): solution<=bestIndividual, solutionError<=bestError, stallCount<=0.
//   - Otherwise stallCount += 1, saturating at all ones.
//   - Equal error is not an improvement.
//  RUN, termination:
//   - Checks use the post-update values, so done rises exactly 1 clk after the edge that sampled the rise.
//   - Priority: target (solutionError<=TargetError) > stall (StallLimit!=0 && stallCount>=StallLimit)
//     > limit (MaxEvaluations!=0 && evalCount>=MaxEvaluations) > abort.
//   - The highest-priority true condition is registered into reason and state -> DONE.
//   - abort in the same cycle as a rise: the rise is processed first, then the priority above applies.
//   - arm in RUN is ignored.
//  DONE:
//   - done=1; solution, solutionError, evalCount, stallCount and reason are frozen.
//   - rise is ignored.
//   - arm=1 -> RUN with the same clearing as from IDLE; done drops the next cycle.
//  doneStrobe is high for exactly the first cycle of DONE.
//  rst mid-run: returns to IDLE with all outputs 0 on the next edge; overrides arm and abort.
//  Level-high cycle counts once; back-to-back rises need cycle to go low for at least 1 clk between them.
// TESTING
//  1. Reset, arm, then 3 rises with errors 9,4,4 -> evalCount=3, solutionError=4, stallCount=1, running=1.
//  2. Rises with errors 7,0 -> done and doneStrobe 1 clk after the 2nd rise, reason=1, solution=individual of 2nd rise.
//  3. StallLimit=4, errors 5,5,5,5,5 -> done after 5th rise (stallCount=4), reason=2.
//  4. MaxEvaluations=3, errors 9,8,7 -> reason=3, evalCount=3; further rises leave all outputs frozen.
//  5. abort with a simultaneous rise carrying error 0 -> reason=1, not 4; abort alone in RUN -> reason=4.
//  6. Hold cycle high 10 clks -> evalCount=1; rst mid-run -> all outputs 0; re-arm from DONE -> counters cleared, running=1.

Source files
------------

// File: rtl/ga_convergence_monitor.sv
// Convergence monitor for the morphologic GA: counts fitness evaluations, tracks the
// best individual since arm and stops the run on target, stall, evaluation limit or abort.
module ga_convergence_monitor #(
  parameter int unsigned IndividualWidth   = 64,
  parameter int unsigned ErrorWidth        = 5,
  parameter int unsigned EvalCounterWidth  = 16,
  parameter int unsigned StallCounterWidth = 8,
  parameter int unsigned MaxEvaluations    = 1000,
  parameter int unsigned StallLimit        = 64,
  parameter int unsigned TargetError       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         cycle,
  input  logic [IndividualWidth-1:0]   bestIndividual,
  input  logic [ErrorWidth-1:0]        bestError,
  output logic                         running,
  output logic                         done,
  output logic                         doneStrobe,
  output logic [2:0]                   reason,
  output logic [IndividualWidth-1:0]   solution,
  output logic [ErrorWidth-1:0]        solutionError,
  output logic [EvalCounterWidth-1:0]  evalCount,
  output logic [StallCounterWidth-1:0] stallCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateType;

  typedef enum logic [2:0] {
    ReasonNone   = 3'd0,
    ReasonTarget = 3'd1,
    ReasonStall  = 3'd2,
    ReasonLimit  = 3'd3,
    ReasonAbort  = 3'd4
  } reasonType;

  localparam logic [ErrorWidth-1:0]        targetLevel = ErrorWidth'(TargetError);
  localparam logic [StallCounterWidth-1:0] stallLevel  = StallCounterWidth'(StallLimit);
  localparam logic [EvalCounterWidth-1:0]  evalLevel   = EvalCounterWidth'(MaxEvaluations);

  stateType  state;
  reasonType stopReason;
  logic      cyclePrev;
  logic      abortQ;
  logic      rise;

  assign rise = cycle & ~cyclePrev;

  // Stop conditions are evaluated on the registered counters, i.e. one clock after the
  // rise that updated them. abortQ delays abort by the same clock so a coinciding rise
  // is folded in first and can still win with a higher-priority reason.
  always_comb begin
    stopReason = ReasonNone;
    if (solutionError <= targetLevel) begin
      stopReason = ReasonTarget;
    end else if ((StallLimit != 0) && (stallCount >= stallLevel)) begin
      stopReason = ReasonStall;
    end else if ((MaxEvaluations != 0) && (evalCount >= evalLevel)) begin
      stopReason = ReasonLimit;
    end else if (abortQ) begin
      stopReason = ReasonAbort;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cyclePrev     <= 1'b0;
      abortQ        <= 1'b0;
      running       <= 1'b0;
      done          <= 1'b0;
      doneStrobe    <= 1'b0;
      reason        <= '0;
      solution      <= '0;
      solutionError <= '0;
      evalCount     <= '0;
      stallCount    <= '0;
    end else begin
      cyclePrev  <= cycle;
      abortQ     <= abort && (state == RUN);
      doneStrobe <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state         <= RUN;
            running       <= 1'b1;
            done          <= 1'b0;
            reason        <= '0;
            solution      <= '0;
            solutionError <= '1;
            evalCount     <= '0;
            stallCount    <= '0;
          end
        end
        RUN: begin
          if (stopReason != ReasonNone) begin
            state      <= DONE;
            running    <= 1'b0;
            done       <= 1'b1;
            doneStrobe <= 1'b1;
            reason     <= stopReason;
          end else if (rise) begin
            if (evalCount != '1) begin
              evalCount <= evalCount + 1'b1;
            end
            if (bestError < solutionError) begin
              solution      <= bestIndividual;
              solutionError <= bestError;
              stallCount    <= '0;
            end else if (stallCount != '1) begin
              stallCount <= stallCount + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ga_convergence_monitor.sv
// Bench for ga_convergence_monitor: three differently parameterised instances share one
// stimulus stream and are compared every clock against a run-level reference model.
module tb_ga_convergence_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        cycle = 1'b0;
  logic [63:0] bestIndividual = '0;
  logic [4:0]  bestError = '0;

  logic        runningA, doneA, strobeA, runningS, doneS, strobeS, runningM, doneM, strobeM;
  logic [2:0]  reasonA, reasonS, reasonM;
  logic [63:0] solA, solS, solM;
  logic [4:0]  solErrA, solErrS, solErrM;
  logic [15:0] evalA, evalS, evalM;
  logic [7:0]  stallA, stallS, stallM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ga_convergence_monitor dutA (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .cycle(cycle),
    .bestIndividual(bestIndividual), .bestError(bestError),
    .running(runningA), .done(doneA), .doneStrobe(strobeA), .reason(reasonA),
    .solution(solA), .solutionError(solErrA), .evalCount(evalA), .stallCount(stallA)
  );

  ga_convergence_monitor #(.MaxEvaluations(0), .StallLimit(4), .TargetError(0)) dutS (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .cycle(cycle),
    .bestIndividual(bestIndividual), .bestError(bestError),
    .running(runningS), .done(doneS), .doneStrobe(strobeS), .reason(reasonS),
    .solution(solS), .solutionError(solErrS), .evalCount(evalS), .stallCount(stallS)
  );

  ga_convergence_monitor #(.MaxEvaluations(3), .StallLimit(0), .TargetError(2)) dutM (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .cycle(cycle),
    .bestIndividual(bestIndividual), .bestError(bestError),
    .running(runningM), .done(doneM), .doneStrobe(strobeM), .reason(reasonM),
    .solution(solM), .solutionError(solErrM), .evalCount(evalM), .stallCount(stallM)
  );

  // Reference model: one record per instance, advanced once per clock from the run rules.
  typedef struct {
    int          mode;       // 0 idle, 1 running, 2 finished
    bit          abortSeen;  // abort observed while running, acted on next clock
    bit          strobe;
    int          reason;
    int          evals;
    int          stalls;
    int          bestErr;
    logic [63:0] bestInd;
  } runModel;

  runModel mdl[3];
  int      stallLim[3] = '{64, 4, 0};
  int      maxEvals[3] = '{1000, 0, 3};
  int      target[3]   = '{0, 0, 2};
  bit      lastCycle   = 1'b0;

  task automatic modelClock();
    bit seenRise;
    seenRise = cycle && !lastCycle;
    for (int i = 0; i < 3; i++) begin
      int  why;
      bit  wasRunning;
      wasRunning = (mdl[i].mode == 1);
      mdl[i].strobe = 1'b0;
      if (rst) begin
        mdl[i] = '{mode: 0, abortSeen: 1'b0, strobe: 1'b0, reason: 0, evals: 0,
                   stalls: 0, bestErr: 0, bestInd: '0};
        continue;
      end
      if (mdl[i].mode != 1) begin
        if (arm) begin
          mdl[i].mode = 1; mdl[i].reason = 0; mdl[i].evals = 0; mdl[i].stalls = 0;
          mdl[i].bestErr = 31; mdl[i].bestInd = '0;
        end
      end else begin
        why = 0;
        if (mdl[i].bestErr <= target[i]) why = 1;
        else if (stallLim[i] != 0 && mdl[i].stalls >= stallLim[i]) why = 2;
        else if (maxEvals[i] != 0 && mdl[i].evals >= maxEvals[i]) why = 3;
        else if (mdl[i].abortSeen) why = 4;
        if (why != 0) begin
          mdl[i].mode = 2; mdl[i].reason = why; mdl[i].strobe = 1'b1;
        end else if (seenRise) begin
          mdl[i].evals = (mdl[i].evals == 65535) ? 65535 : mdl[i].evals + 1;
          if (int'(bestError) < mdl[i].bestErr) begin
            mdl[i].bestErr = int'(bestError); mdl[i].bestInd = bestIndividual; mdl[i].stalls = 0;
          end else begin
            mdl[i].stalls = (mdl[i].stalls == 255) ? 255 : mdl[i].stalls + 1;
          end
        end
      end
      mdl[i].abortSeen = abort && wasRunning;
    end
    lastCycle = rst ? 1'b0 : cycle;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkDut(input int i, input string name, input logic run, input logic dn,
                          input logic stb, input logic [2:0] rsn, input logic [63:0] sol,
                          input logic [4:0] se, input logic [15:0] ev, input logic [7:0] st);
    checkVal({name, ".running"}, 64'(run), 64'(mdl[i].mode == 1));
    checkVal({name, ".done"}, 64'(dn), 64'(mdl[i].mode == 2));
    checkVal({name, ".doneStrobe"}, 64'(stb), 64'(mdl[i].strobe));
    checkVal({name, ".reason"}, 64'(rsn), 64'(mdl[i].reason));
    checkVal({name, ".solution"}, sol, mdl[i].bestInd);
    checkVal({name, ".solutionError"}, 64'(se), 64'(mdl[i].bestErr));
    checkVal({name, ".evalCount"}, 64'(ev), 64'(mdl[i].evals));
    checkVal({name, ".stallCount"}, 64'(st), 64'(mdl[i].stalls));
  endtask

  // One clock: inputs were set away from the edge; model advances on the edge, DUTs checked 1 ns later.
  task automatic step();
    @(posedge clk);
    modelClock();
    #1;
    checkDut(0, "A", runningA, doneA, strobeA, reasonA, solA, solErrA, evalA, stallA);
    checkDut(1, "S", runningS, doneS, strobeS, reasonS, solS, solErrS, evalS, stallS);
    checkDut(2, "M", runningM, doneM, strobeM, reasonM, solM, solErrM, evalM, stallM);
  endtask

  task automatic pulseRise(input logic [4:0] err, input logic [63:0] ind);
    bestError = err; bestIndividual = ind; cycle = 1'b1;
    step();
    cycle = 1'b0;
    step();
  endtask

  task automatic doReset();
    rst = 1'b1; arm = 1'b0; abort = 1'b0; cycle = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic doArm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) mdl[i] = '{0, 1'b0, 1'b0, 0, 0, 0, 0, 64'h0};
    #2;
    doReset();
    checkVal("reset running", 64'(runningA), 64'd0);
    checkVal("reset solutionError", 64'(solErrA), 64'd0);

    // Improvements and an equal-error stall
    doArm();
    checkVal("arm solutionError", 64'(solErrA), 64'h1f);
    pulseRise(5'd9, 64'h9999);
    pulseRise(5'd4, 64'h4444);
    pulseRise(5'd4, 64'h4445);
    checkVal("s1 evalCount", 64'(evalA), 64'd3);
    checkVal("s1 solutionError", 64'(solErrA), 64'd4);
    checkVal("s1 stallCount", 64'(stallA), 64'd1);
    checkVal("s1 running", 64'(runningA), 64'd1);
    checkVal("s1 solution", solA, 64'h4444);

    // Target reached: done one clock after the sampling edge
    pulseRise(5'd7, 64'h7777);
    bestError = 5'd0; bestIndividual = 64'hC0FFEE00DEADBEEF; cycle = 1'b1;
    step();
    checkVal("s2 not yet done", 64'(doneA), 64'd0);
    cycle = 1'b0;
    step();
    checkVal("s2 done", 64'(doneA), 64'd1);
    checkVal("s2 doneStrobe", 64'(strobeA), 64'd1);
    checkVal("s2 reason", 64'(reasonA), 64'd1);
    checkVal("s2 solution", solA, 64'hC0FFEE00DEADBEEF);
    step();
    checkVal("s2 strobe single", 64'(strobeA), 64'd0);

    // Stall limit
    doReset();
    doArm();
    for (int k = 0; k < 5; k++) pulseRise(5'd5, 64'(k + 100));
    checkVal("s3 stallCount", 64'(stallS), 64'd4);
    checkVal("s3 reason", 64'(reasonS), 64'd2);
    checkVal("s3 solution", solS, 64'd100);

    // Evaluation limit, then frozen
    doReset();
    doArm();
    pulseRise(5'd9, 64'h1); pulseRise(5'd8, 64'h2); pulseRise(5'd7, 64'h3);
    checkVal("s4 reason", 64'(reasonM), 64'd3);
    checkVal("s4 evalCount", 64'(evalM), 64'd3);
    pulseRise(5'd1, 64'h4); pulseRise(5'd0, 64'h5);
    checkVal("s4 frozen evalCount", 64'(evalM), 64'd3);
    checkVal("s4 frozen solution", solM, 64'h3);

    // Abort with a coinciding target rise, then abort alone
    doReset();
    doArm();
    pulseRise(5'd6, 64'h66);
    abort = 1'b1; cycle = 1'b1; bestError = 5'd0; bestIndividual = 64'hAB;
    step();
    abort = 1'b0; cycle = 1'b0;
    step();
    checkVal("s5 target beats abort", 64'(reasonA), 64'd1);
    doArm();
    checkVal("s5 rearm done low", 64'(doneA), 64'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    checkVal("s5 abort reason", 64'(reasonA), 64'd4);

    // Level-high cycle counts once; reset mid-run; re-arm from DONE
    doReset();
    doArm();
    cycle = 1'b1; bestError = 5'd12;
    for (int k = 0; k < 10; k++) step();
    cycle = 1'b0;
    step();
    checkVal("s6 level evalCount", 64'(evalA), 64'd1);
    rst = 1'b1; arm = 1'b1; abort = 1'b1;
    step();
    rst = 1'b0; arm = 1'b0; abort = 1'b0;
    checkVal("s6 rst solutionError", 64'(solErrA), 64'd0);
    checkVal("s6 rst evalCount", 64'(evalA), 64'd0);
    doArm();
    pulseRise(5'd20, 64'h20);
    abort = 1'b1; step(); abort = 1'b0; step();
    checkVal("s6 done before rearm", 64'(doneA), 64'd1);
    doArm();
    checkVal("s6 rearm evalCount", 64'(evalA), 64'd0);
    checkVal("s6 rearm running", 64'(runningA), 64'd1);

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 199) == 0);
      arm   = ($urandom_range(0, 29) == 0);
      abort = ($urandom_range(0, 59) == 0);
      cycle = $urandom_range(0, 1);
      bestError = 5'($urandom_range(0, 31));
      bestIndividual = {$urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
